// File: rtl/spi_master_ctrl.sv
// spi_master_ctrl: parametrised SPI master, single i_clk domain.
//   Takes one word per valid/ready handshake and runs a full-duplex transfer
//   in any CPOL/CPHA mode, with configurable width, SCLK divider, bit order
//   and chip-select guard time. The received word is returned with a 1-cycle
//   valid pulse when the transfer completes.
// Ports:
//   i_clk, i_rst_n       system clock, async active-low reset
//   o_spi_clk/cs/mosi    SPI pins (cs active low, one per slave)
//   i_spi_miso           SPI data in, sampled on i_clk
//   i_user_data/cs_sel   word and target slave, captured at the handshake
//   i_user_valid         request; o_user_ready high only in IDLE
//   o_user_read_data     last received word; o_user_read_valid pulses on update
//   o_busy               high whenever a transfer is in progress
module spi_master_ctrl #(
  parameter int P_DATA_WIDTH = 8,
  parameter int P_CPOL       = 0,
  parameter int P_CPHA       = 0,
  parameter int P_CLK_DIV    = 2,
  parameter int P_MSB_FIRST  = 1,
  parameter int P_CS_NUM     = 1,
  parameter int P_CS_W       = (P_CS_NUM > 1) ? $clog2(P_CS_NUM) : 1
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  output logic                    o_spi_clk,
  output logic [P_CS_NUM-1:0]     o_spi_cs,
  output logic                    o_spi_mosi,
  input  logic                    i_spi_miso,
  input  logic [P_DATA_WIDTH-1:0] i_user_data,
  input  logic [P_CS_W-1:0]       i_user_cs_sel,
  input  logic                    i_user_valid,
  output logic                    o_user_ready,
  output logic [P_DATA_WIDTH-1:0] o_user_read_data,
  output logic                    o_user_read_valid,
  output logic                    o_busy
);
  localparam int W  = P_DATA_WIDTH;
  localparam int CW = $clog2(P_CLK_DIV + 1);
  localparam int EW = $clog2(2 * W + 1);
  localparam logic [CW-1:0] DIV_LAST   = CW'(P_CLK_DIV - 1);
  localparam logic [CW-1:0] SETUP_LAST = CW'(P_CLK_DIV);
  localparam logic [EW-1:0] EDGE_LAST  = EW'(2 * W);

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_XFER, S_HOLD} state_e;

  state_e                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [EW-1:0]         edge_q, edge_d;
  logic                  sclk_q, sclk_d;
  logic [P_CS_NUM-1:0]   cs_q, cs_d, cs_dec;
  logic                  mosi_q, mosi_d;
  logic [W-1:0]          tx_q, tx_d;
  logic [W-1:0]          rx_q, rx_d;
  logic [W-1:0]          rdata_q, rdata_d;
  logic                  rvalid_q, rvalid_d;
  logic [EW-1:0]         nxt_edge;
  logic                  smp_edge;

  // Bit-order helpers: head is the next bit to put on the wire.
  function automatic logic head(input logic [W-1:0] v);
    return (P_MSB_FIRST != 0) ? v[W-1] : v[0];
  endfunction
  function automatic logic [W-1:0] adv(input logic [W-1:0] v);
    return (P_MSB_FIRST != 0) ? (v << 1) : (v >> 1);
  endfunction
  function automatic logic [W-1:0] shin(input logic [W-1:0] v, input logic b);
    return (P_MSB_FIRST != 0) ? {v[W-2:0], b} : {b, v[W-1:1]};
  endfunction

  // Out-of-range selects decode to no CS asserted; the transfer still runs.
  always_comb begin
    cs_dec = '1;
    for (int i = 0; i < P_CS_NUM; i++)
      if (i_user_cs_sel == P_CS_W'(i)) cs_dec[i] = 1'b0;
  end

  // Edges are numbered 1..2W; odd edges are leading, even are trailing.
  assign nxt_edge = edge_q + EW'(1);
  assign smp_edge = (P_CPHA == 0) ? nxt_edge[0] : ~nxt_edge[0];

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    edge_d   = edge_q;
    sclk_d   = sclk_q;
    cs_d     = cs_q;
    mosi_d   = mosi_q;
    tx_d     = tx_q;
    rx_d     = rx_q;
    rdata_d  = rdata_q;
    rvalid_d = 1'b0;
    unique case (state_q)
      S_IDLE: if (i_user_valid) begin
        state_d = S_SETUP;
        cnt_d   = '0;
        edge_d  = '0;
        cs_d    = cs_dec;
        rx_d    = '0;
        if (P_CPHA == 0) begin
          // First bit must be on the wire before the leading edge.
          mosi_d = head(i_user_data);
          tx_d   = adv(i_user_data);
        end else begin
          tx_d   = i_user_data;
        end
      end
      // Setup spans the acceptance cycle plus D guard cycles, which places
      // read_valid (2W+2)*D+1 cycles after the handshake.
      S_SETUP: begin
        if (cnt_q == SETUP_LAST) begin
          state_d = S_XFER;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_XFER: begin
        if (cnt_q == DIV_LAST) begin
          cnt_d  = '0;
          sclk_d = ~sclk_q;
          edge_d = nxt_edge;
          if (smp_edge) begin
            rx_d = shin(rx_q, i_spi_miso);
          end else if (nxt_edge != EDGE_LAST) begin
            // Non-sample edges launch the next bit, except the final edge.
            mosi_d = head(tx_q);
            tx_d   = adv(tx_q);
          end
          if (nxt_edge == EDGE_LAST) state_d = S_HOLD;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_HOLD: begin
        if (cnt_q == DIV_LAST) begin
          state_d  = S_IDLE;
          cs_d     = '1;
          rdata_d  = rx_q;
          rvalid_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      edge_q   <= '0;
      sclk_q   <= 1'(P_CPOL);
      cs_q     <= '1;
      mosi_q   <= 1'b0;
      tx_q     <= '0;
      rx_q     <= '0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      edge_q   <= edge_d;
      sclk_q   <= sclk_d;
      cs_q     <= cs_d;
      mosi_q   <= mosi_d;
      tx_q     <= tx_d;
      rx_q     <= rx_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
    end
  end

  assign o_spi_clk         = sclk_q;
  assign o_spi_cs          = cs_q;
  assign o_spi_mosi        = mosi_q;
  assign o_user_ready      = (state_q == S_IDLE);
  assign o_busy            = (state_q != S_IDLE);
  assign o_user_read_data  = rdata_q;
  assign o_user_read_valid = rvalid_q;
endmodule

// File: tb/tb_spi_master_ctrl.sv
// Directed bench for spi_master_ctrl: four instances cover mode 0 with four
// chip selects, mode 3, LSB-first, and D=1/W=16. Simple slave models shift
// out a known word; MOSI is captured on rising SCLK.
module tb_spi_master_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---- u0: mode 0, W=8, D=2, N=4 ----
  logic       sclk0, mosi0, miso0, valid0, ready0, rv0, busy0;
  logic [3:0] cs0;
  logic [7:0] data0, rdata0, s0_val, s0_sh, m0_cap;
  logic [1:0] sel0;
  spi_master_ctrl #(.P_CS_NUM(4)) u0 (
    .i_clk(clk), .i_rst_n(rst_n), .o_spi_clk(sclk0), .o_spi_cs(cs0),
    .o_spi_mosi(mosi0), .i_spi_miso(miso0), .i_user_data(data0),
    .i_user_cs_sel(sel0), .i_user_valid(valid0), .o_user_ready(ready0),
    .o_user_read_data(rdata0), .o_user_read_valid(rv0), .o_busy(busy0));
  wire cs0_any = ~&cs0;
  assign miso0 = s0_sh[7];
  always @(posedge cs0_any) s0_sh <= s0_val;
  always @(negedge sclk0) if (cs0_any) s0_sh <= s0_sh << 1;
  always @(posedge sclk0) m0_cap <= {m0_cap[6:0], mosi0};

  // ---- u3: mode 3, W=8, D=2 ----
  logic       sclk3, mosi3, miso3, valid3, ready3, rv3, busy3;
  logic [0:0] cs3, sel3;
  logic [7:0] data3, rdata3, s3_val, s3_sh, m3_cap;
  spi_master_ctrl #(.P_CPOL(1), .P_CPHA(1)) u3 (
    .i_clk(clk), .i_rst_n(rst_n), .o_spi_clk(sclk3), .o_spi_cs(cs3),
    .o_spi_mosi(mosi3), .i_spi_miso(miso3), .i_user_data(data3),
    .i_user_cs_sel(sel3), .i_user_valid(valid3), .o_user_ready(ready3),
    .o_user_read_data(rdata3), .o_user_read_valid(rv3), .o_busy(busy3));
  assign miso3 = s3_sh[7];
  always @(negedge cs3[0]) s3_sh <= s3_val;
  always @(posedge sclk3) if (!cs3[0]) s3_sh <= s3_sh << 1;
  always @(posedge sclk3) m3_cap <= {m3_cap[6:0], mosi3};

  // ---- ul: mode 0, LSB first ----
  logic       sclkl, mosil, misol, validl, readyl, rvl, busyl, l_first;
  logic [0:0] csl, sell;
  logic [7:0] datal, rdatal, sl_val, sl_sh, ml_cap;
  int         l_cnt = 0;
  spi_master_ctrl #(.P_MSB_FIRST(0)) ul (
    .i_clk(clk), .i_rst_n(rst_n), .o_spi_clk(sclkl), .o_spi_cs(csl),
    .o_spi_mosi(mosil), .i_spi_miso(misol), .i_user_data(datal),
    .i_user_cs_sel(sell), .i_user_valid(validl), .o_user_ready(readyl),
    .o_user_read_data(rdatal), .o_user_read_valid(rvl), .o_busy(busyl));
  assign misol = sl_sh[0];
  always @(negedge csl[0]) begin sl_sh <= sl_val; l_cnt <= 0; end
  always @(negedge sclkl) if (!csl[0]) sl_sh <= sl_sh >> 1;
  always @(posedge sclkl) begin
    ml_cap <= {mosil, ml_cap[7:1]};
    if (l_cnt == 0) l_first <= mosil;
    l_cnt <= l_cnt + 1;
  end

  // ---- u16: mode 0, W=16, D=1 ----
  logic        sclk16, mosi16, miso16, valid16, ready16, rv16, busy16;
  logic [0:0]  cs16, sel16;
  logic [15:0] data16, rdata16, s16_val, s16_sh, m16_cap;
  spi_master_ctrl #(.P_DATA_WIDTH(16), .P_CLK_DIV(1)) u16 (
    .i_clk(clk), .i_rst_n(rst_n), .o_spi_clk(sclk16), .o_spi_cs(cs16),
    .o_spi_mosi(mosi16), .i_spi_miso(miso16), .i_user_data(data16),
    .i_user_cs_sel(sel16), .i_user_valid(valid16), .o_user_ready(ready16),
    .o_user_read_data(rdata16), .o_user_read_valid(rv16), .o_busy(busy16));
  assign miso16 = s16_sh[15];
  always @(negedge cs16[0]) s16_sh <= s16_val;
  always @(negedge sclk16) if (!cs16[0]) s16_sh <= s16_sh << 1;
  always @(posedge sclk16) m16_cap <= {m16_cap[14:0], mosi16};

  int t0, n, rv_cnt;

  initial begin
    valid0 = 0; data0 = '0; sel0 = '0; s0_val = '0;
    valid3 = 0; data3 = '0; sel3 = '0; s3_val = '0;
    validl = 0; datal = '0; sell = '0; sl_val = '0;
    valid16 = 0; data16 = '0; sel16 = '0; s16_val = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Reset state
    chk("rst_sclk0", 32'(sclk0), 32'h0);
    chk("rst_cs0", 32'(cs0), 32'hF);
    chk("rst_mosi0", 32'(mosi0), 32'h0);
    chk("rst_ready0", 32'(ready0), 32'h1);
    chk("rst_busy0", 32'(busy0), 32'h0);
    chk("rst_rdata0", 32'(rdata0), 32'h0);
    chk("rst_rv0", 32'(rv0), 32'h0);
    chk("rst_sclk3_idle", 32'(sclk3), 32'h1);

    // Mode 0, cs_sel=2 then 1 back-to-back with valid held high
    s0_val = 8'h3C; data0 = 8'hA5; sel0 = 2'd2; valid0 = 1'b1;
    @(negedge clk);
    t0 = cyc;
    chk("m0_busy", 32'(busy0), 32'h1);
    chk("m0_ready_low", 32'(ready0), 32'h0);
    chk("m0_cs_sel2", 32'(cs0), 32'hB);
    data0 = 8'h5A; sel0 = 2'd1; s0_val = 8'h96;
    repeat (10) @(negedge clk);
    chk("m0_cs_sel2_mid", 32'(cs0), 32'hB);
    n = 0;
    while (!rv0 && n < 100) begin @(negedge clk); n++; end
    chk("m0_latency", 32'(cyc - t0), 32'd37);
    chk("m0_rdata", 32'(rdata0), 32'h3C);
    chk("m0_mosi_bits", 32'(m0_cap), 32'hA5);
    chk("m0_cs_gap", 32'(cs0), 32'hF);
    chk("m0_ready_rv", 32'(ready0), 32'h1);
    @(negedge clk);
    t0 = cyc; valid0 = 1'b0;
    chk("m0_rv_pulse", 32'(rv0), 32'h0);
    chk("m0_cs_sel1", 32'(cs0), 32'hD);
    chk("m0_busy2", 32'(busy0), 32'h1);
    n = 0;
    while (!rv0 && n < 100) begin @(negedge clk); n++; end
    chk("m0_latency2", 32'(cyc - t0), 32'd37);
    chk("m0_rdata2", 32'(rdata0), 32'h96);
    chk("m0_mosi_bits2", 32'(m0_cap), 32'h5A);
    repeat (3) @(negedge clk);
    chk("m0_rdata_hold", 32'(rdata0), 32'h96);

    // Mode 3
    s3_val = 8'hF0; data3 = 8'h81; valid3 = 1'b1;
    @(negedge clk);
    t0 = cyc; valid3 = 1'b0;
    chk("m3_cs", 32'(cs3), 32'h0);
    chk("m3_sclk_setup", 32'(sclk3), 32'h1);
    n = 0;
    while (!rv3 && n < 100) begin @(negedge clk); n++; end
    chk("m3_latency", 32'(cyc - t0), 32'd37);
    chk("m3_rdata", 32'(rdata3), 32'hF0);
    chk("m3_mosi_bits", 32'(m3_cap), 32'h81);
    chk("m3_sclk_idle", 32'(sclk3), 32'h1);

    // LSB first
    sl_val = 8'h80; datal = 8'h01; validl = 1'b1;
    @(negedge clk);
    t0 = cyc; validl = 1'b0;
    chk("lsb_mosi_setup", 32'(mosil), 32'h1);
    n = 0;
    while (!rvl && n < 100) begin @(negedge clk); n++; end
    chk("lsb_first_bit", 32'(l_first), 32'h1);
    chk("lsb_mosi_bits", 32'(ml_cap), 32'h01);
    chk("lsb_rdata", 32'(rdatal), 32'h80);

    // D=1, W=16
    s16_val = 16'h1234; data16 = 16'hBEEF; valid16 = 1'b1;
    @(negedge clk);
    t0 = cyc; valid16 = 1'b0;
    repeat (5) @(negedge clk);
    chk("d1_sclk_a", 32'(sclk16), 32'h1);
    @(negedge clk);
    chk("d1_sclk_b", 32'(sclk16), 32'h0);
    @(negedge clk);
    chk("d1_sclk_c", 32'(sclk16), 32'h1);
    n = 0;
    while (!rv16 && n < 100) begin @(negedge clk); n++; end
    chk("d1_latency", 32'(cyc - t0), 32'd35);
    chk("d1_rdata", 32'(rdata16), 32'h1234);
    chk("d1_mosi_bits", 32'(m16_cap), 32'hBEEF);

    // Reset in the middle of a transfer
    s0_val = 8'h55; data0 = 8'hFF; sel0 = 2'd0; valid0 = 1'b1;
    @(negedge clk);
    valid0 = 1'b0;
    repeat (10) @(negedge clk);
    chk("mid_busy", 32'(busy0), 32'h1);
    chk("mid_mosi", 32'(mosi0), 32'h1);
    rst_n = 1'b0;
    #1;
    chk("abort_sclk", 32'(sclk0), 32'h0);
    chk("abort_cs", 32'(cs0), 32'hF);
    chk("abort_mosi", 32'(mosi0), 32'h0);
    chk("abort_ready", 32'(ready0), 32'h1);
    chk("abort_busy", 32'(busy0), 32'h0);
    chk("abort_rdata", 32'(rdata0), 32'h0);
    chk("abort_rv", 32'(rv0), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    rv_cnt = 0;
    repeat (60) begin
      @(negedge clk);
      if (rv0) rv_cnt++;
    end
    chk("abort_no_rv", 32'(rv_cnt), 32'h0);
    chk("abort_idle", 32'(ready0), 32'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
